// File: rtl/gpio_rx_monitor.sv
// gpio_rx_monitor: synchronises, debounces, edge-flags and times an asynchronous GPIO input.
// Optional stuck-level detection is built only when the macro GPIO_RX_TIMEOUT_EN is defined.
module gpio_rx_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 16,
    parameter int WIDTH_W        = 16,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_gpio,
    input  logic               i_clear,
    output logic               o_level,
    output logic               o_rise,
    output logic               o_fall,
    output logic [WIDTH_W-1:0] o_width,
    output logic               o_width_valid,
    output logic               o_width_is_high,
    output logic [15:0]        o_edge_cnt,
    output logic               o_timeout
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CAND   = 1'b1
    } deb_state_t;

    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]   DEB_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [WIDTH_W-1:0] WIDTH_ZERO = {WIDTH_W{1'b0}};
    localparam logic [WIDTH_W-1:0] WIDTH_ONE  = WIDTH_W'(1);
    // hold_extra_r stores hold_cnt-1, so its ceiling is one below the hold_cnt ceiling
    localparam logic [WIDTH_W-1:0] HOLD_EXTRA_MAX = ~WIDTH_ONE;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    deb_state_t             state_r;
    deb_state_t             state_nxt_s;
    logic [DEB_W-1:0]       deb_cnt_r;
    logic [DEB_W-1:0]       deb_cnt_nxt_s;
    logic                   toggle_s;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   width_valid_r;
    logic                   width_is_high_r;
    logic                   timeout_r;
    logic [WIDTH_W-1:0]     width_r;
    logic [WIDTH_W-1:0]     hold_extra_r;
    logic [WIDTH_W-1:0]     hold_s;
    logic [15:0]            edge_cnt_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign hold_s     = hold_extra_r + WIDTH_ONE;

    // Synchroniser chain bringing the pin into the clock domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_gpio};
        end
    end

    // Debounce state, candidate counter and the accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_STABLE;
            deb_cnt_r <= DEB_ZERO;
            level_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            level_r   <= level_r ^ toggle_s;
        end
    end

    // Debounce next-state: a candidate must differ for DEB_CYCLES consecutive samples
    always_comb begin
        state_nxt_s   = state_r;
        deb_cnt_nxt_s = deb_cnt_r;
        toggle_s      = 1'b0;
        case (state_r)
            ST_STABLE: begin
                if (sync_out_s != level_r) begin
                    if (DEB_CYCLES == 1) begin
                        toggle_s      = 1'b1;
                        deb_cnt_nxt_s = DEB_ZERO;
                    end else begin
                        state_nxt_s   = ST_CAND;
                        deb_cnt_nxt_s = DEB_ONE;
                    end
                end else begin
                    deb_cnt_nxt_s = DEB_ZERO;
                end
            end
            ST_CAND: begin
                if (sync_out_s == level_r) begin
                    state_nxt_s   = ST_STABLE;
                    deb_cnt_nxt_s = DEB_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    toggle_s      = 1'b1;
                    state_nxt_s   = ST_STABLE;
                    deb_cnt_nxt_s = DEB_ZERO;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_STABLE;
                deb_cnt_nxt_s = DEB_ZERO;
            end
        endcase
    end

    // Edge pulses, width capture, edge counter and saturating hold counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rise_r          <= 1'b0;
            fall_r          <= 1'b0;
            width_valid_r   <= 1'b0;
            width_r         <= WIDTH_ZERO;
            width_is_high_r <= 1'b0;
            edge_cnt_r      <= 16'd0;
            hold_extra_r    <= WIDTH_ZERO;
        end else begin
            rise_r        <= toggle_s & ~level_r;
            fall_r        <= toggle_s & level_r;
            width_valid_r <= toggle_s;
            if (toggle_s) begin
                width_r         <= hold_s;
                width_is_high_r <= level_r;
            end else begin
                width_r         <= width_r;
                width_is_high_r <= width_is_high_r;
            end
            // a clear coinciding with an edge still counts that edge
            if (toggle_s) begin
                edge_cnt_r <= i_clear ? 16'd1 : (edge_cnt_r + 16'd1);
            end else if (i_clear) begin
                edge_cnt_r <= 16'd0;
            end else begin
                edge_cnt_r <= edge_cnt_r;
            end
            if (toggle_s || i_clear) begin
                hold_extra_r <= WIDTH_ZERO;
            end else if (hold_extra_r != HOLD_EXTRA_MAX) begin
                hold_extra_r <= hold_extra_r + WIDTH_ONE;
            end else begin
                hold_extra_r <= hold_extra_r;
            end
        end
    end

`ifdef GPIO_RX_TIMEOUT_EN
    localparam logic [WIDTH_W-1:0] TIMEOUT_VAL = WIDTH_W'(TIMEOUT_CYCLES);

    // Sticky stuck-level flag; an edge or clear in the same cycle wins over setting it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_r <= 1'b0;
        end else if (toggle_s || i_clear) begin
            timeout_r <= 1'b0;
        end else if (hold_s == TIMEOUT_VAL) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end
`else
    assign timeout_r = 1'b0;
`endif

    assign o_level         = level_r;
    assign o_rise          = rise_r;
    assign o_fall          = fall_r;
    assign o_width         = width_r;
    assign o_width_valid   = width_valid_r;
    assign o_width_is_high = width_is_high_r;
    assign o_edge_cnt      = edge_cnt_r;
    assign o_timeout       = timeout_r;

endmodule

// File: tb/tb_gpio_rx_monitor.sv
// Bench for gpio_rx_monitor: directed scenarios plus random pin activity, checked every
// cycle against a window-based behavioural model of the debounced level and its statistics.
module tb_gpio_rx_monitor;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int WW   = 8;
    localparam int TMO  = 50;
    localparam int WMAX = (1 << WW) - 1;
`ifdef GPIO_RX_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gpio = 1'b0;
    logic clr = 1'b0;
    logic level, rise, fall, wv, wh, tmo;
    logic [WW-1:0] width;
    logic [15:0] ecnt;

    int total = 0;
    int bad = 0;
    int n_edges = 0;
    int vw_q[$];

    // behavioural model state
    int cyc, start, last_tog;
    int m_level, m_rise, m_fall, m_wv, m_wh, m_to, m_width, m_ecnt;
    bit pin_q[$];
    bit samp_q[$];

    gpio_rx_monitor #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .WIDTH_W(WW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_gpio(gpio), .i_clear(clr),
        .o_level(level), .o_rise(rise), .o_fall(fall), .o_width(width),
        .o_width_valid(wv), .o_width_is_high(wh), .o_edge_cnt(ecnt), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; start = 0; last_tog = 0;
        m_level = 0; m_rise = 0; m_fall = 0; m_wv = 0; m_wh = 0; m_to = 0;
        m_width = 0; m_ecnt = 0;
        pin_q = {};
        samp_q = {};
        for (int i = 0; i < SYNC; i++) pin_q.push_back(1'b0);
    endtask

    // Level changes once DEB consecutive samples since the last change all differ from it
    task automatic model_step();
        bit smp;
        bit tog;
        int w;
        smp = pin_q.pop_front();
        pin_q.push_back(gpio);
        cyc++;
        samp_q.push_back(smp);
        if (samp_q.size() > DEB) void'(samp_q.pop_front());
        tog = (cyc - last_tog >= DEB) && (samp_q.size() == DEB);
        foreach (samp_q[i]) if (int'(samp_q[i]) == m_level) tog = 1'b0;
        m_rise = (tog && m_level == 0) ? 1 : 0;
        m_fall = (tog && m_level == 1) ? 1 : 0;
        m_wv   = tog ? 1 : 0;
        if (tog) begin
            w = cyc - start;
            m_width = (w > WMAX) ? WMAX : w;
            m_wh = m_level;
            m_level = 1 - m_level;
            last_tog = cyc;
            m_ecnt = clr ? 1 : ((m_ecnt + 1) % 65536);
        end else if (clr) begin
            m_ecnt = 0;
        end
        if (tog || clr) start = cyc;
        m_to = (TO_EN == 1 && (cyc - start) >= TMO) ? 1 : 0;
    endtask

    task automatic compare();
        expect_eq("level", level, m_level);
        expect_eq("rise", rise, m_rise);
        expect_eq("fall", fall, m_fall);
        expect_eq("width_valid", wv, m_wv);
        expect_eq("width_is_high", wh, m_wh);
        expect_eq("width", width, m_width);
        expect_eq("edge_cnt", ecnt, m_ecnt);
        expect_eq("timeout", tmo, m_to);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare();
        if (rise || fall) n_edges++;
        if (wv) vw_q.push_back(int'(width));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
    endtask

    task automatic wait_edge(string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(rise || fall) && k < 30);
        total++;
        if (!(rise || fall)) begin
            bad++;
            $display("FAIL %s: no edge within %0d cycles", nm, k);
        end
    endtask

    initial begin
        int e0;
        int len;
        model_reset();

        // 1: pin high through reset; first edge 6 cycles after release
        gpio = 1'b1;
        ticks(3);
        expect_eq("t1 reset level", level, 0);
        rst_n = 1'b1;
        ticks(5);
        expect_eq("t1 no rise yet", rise, 0);
        tick();
        expect_eq("t1 rise", rise, 1);
        expect_eq("t1 width", width, 6);
        expect_eq("t1 is_high", wh, 0);
        expect_eq("t1 edge_cnt", ecnt, 1);

        // 2: a 3-cycle pulse is filtered out
        gpio = 1'b0;
        assert_reset();
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        e0 = n_edges;
        gpio = 1'b1;
        ticks(3);
        gpio = 1'b0;
        ticks(20);
        expect_eq("t2 edges", n_edges - e0, 0);
        expect_eq("t2 level", level, 0);
        expect_eq("t2 edge_cnt", ecnt, 0);

        // 3: square wave 20/20 for 4 periods
        vw_q = {};
        e0 = n_edges;
        for (int p = 0; p < 4; p++) begin
            gpio = 1'b1; ticks(20);
            gpio = 1'b0; ticks(20);
        end
        ticks(10);
        expect_eq("t3 edges", n_edges - e0, 8);
        expect_eq("t3 edge_cnt", ecnt, 8);
        expect_eq("t3 widths", vw_q.size(), 8);
        for (int i = 1; i < vw_q.size(); i++) expect_eq("t3 width20", vw_q[i], 20);

        // 4: long low level saturates the width
        ticks(290);
        gpio = 1'b1;
        ticks(10);
        expect_eq("t4 width sat", width, 255);
        expect_eq("t4 is_high", wh, 0);

        // 5: timeout 50 cycles after an edge, cleared by i_clear and by an edge
        gpio = 1'b0;
        wait_edge("t5 fall");
        ticks(49);
        expect_eq("t5 timeout early", tmo, 0);
        tick();
        expect_eq("t5 timeout set", tmo, TO_EN);
        ticks(5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_eq("t5 timeout clr", tmo, 0);
        expect_eq("t5 edge_cnt clr", ecnt, 0);
        ticks(60);
        expect_eq("t5 timeout again", tmo, TO_EN);
        gpio = 1'b1;
        wait_edge("t5 rise");
        expect_eq("t5 timeout edge", tmo, 0);

        // 6a: reset mid-debounce
        gpio = 1'b0;
        wait_edge("t6 fall");
        ticks(10);
        gpio = 1'b1;
        ticks(4);
        assert_reset();
        expect_eq("t6a level", level, 0);
        gpio = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        e0 = n_edges;
        ticks(20);
        expect_eq("t6a edges", n_edges - e0, 0);

        // 6b: reset in the edge cycle
        gpio = 1'b1;
        ticks(6);
        expect_eq("t6b rise", rise, 1);
        assert_reset();
        expect_eq("t6b rise rst", rise, 0);
        expect_eq("t6b edge_cnt rst", ecnt, 0);
        gpio = 1'b0;
        rst_n = 1'b1;
        e0 = n_edges;
        ticks(20);
        expect_eq("t6b edges", n_edges - e0, 0);

        // 6c: clear coincident with an edge
        ticks(10);
        gpio = 1'b1;
        ticks(5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_eq("t6c rise", rise, 1);
        expect_eq("t6c edge_cnt", ecnt, 1);
        expect_eq("t6c width", width, 36);
        expect_eq("t6c is_high", wh, 0);
        tick();
        expect_eq("t6c edge_cnt hold", ecnt, 1);

        // random pin runs with sporadic clears
        for (int r = 0; r < 120; r++) begin
            gpio = ~gpio;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 80);
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(0, 60) == 0);
                tick();
            end
            clr = 1'b0;
        end
        ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
